// File: rtl/viterbi_pkg.sv
// viterbi_pkg -- shared helpers for the Viterbi path-metric unit.
//   ns_of     : number of trellis states for constraint length k
//   stw_of    : width of a state index for constraint length k
//   parity    : XOR reduction used for branch labels
//   sat_add   : unsigned add clamped to a caller-supplied ceiling
package viterbi_pkg;

  function automatic int ns_of(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int stw_of(input int k);
    return k - 1;
  endfunction

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // The sum is formed one bit wider than the operands so the carry is never
  // lost before the clamp is applied.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/viterbi_bmu.sv
// viterbi_bmu -- combinational branch-metric generator.
//   i_sym0, i_sym1 : soft values for code bits 0 and 1 (0 = confident '0')
//   o_bm_p0[n]     : metric of the branch from predecessor p0 into state n
//   o_bm_p1[n]     : metric of the branch from predecessor p1 into state n
module viterbi_bmu
  import viterbi_pkg::*;
#(
  parameter int           K  = 4,
  parameter logic [K-1:0] G0 = 4'b1011,
  parameter logic [K-1:0] G1 = 4'b1111,
  parameter int           SW = 3,
  localparam int          NS = ns_of(K),
  localparam int          STW = stw_of(K)
) (
  input  logic [SW-1:0]         i_sym0,
  input  logic [SW-1:0]         i_sym1,
  output logic [NS-1:0][SW:0]   o_bm_p0,
  output logic [NS-1:0][SW:0]   o_bm_p1
);

  localparam logic [SW-1:0] SMAX = '1;

  // Distance of each received symbol to an expected '0' (index 0) or '1'.
  logic [SW-1:0] w_dist0 [2];
  logic [SW-1:0] w_dist1 [2];

  assign w_dist0[0] = i_sym0;
  assign w_dist0[1] = SMAX - i_sym0;
  assign w_dist1[0] = i_sym1;
  assign w_dist1[1] = SMAX - i_sym1;

  // The encoder register for the branch p_j -> n is {n[K-2], p_j}, which is
  // simply {n, j}: the state index followed by the predecessor selector.
  logic [K-1:0] w_reg0;
  logic [K-1:0] w_reg1;
  logic         w_e00, w_e01, w_e10, w_e11;

  always_comb begin
    o_bm_p0 = '0;
    o_bm_p1 = '0;
    w_reg0  = '0;
    w_reg1  = '0;
    w_e00   = 1'b0;
    w_e01   = 1'b0;
    w_e10   = 1'b0;
    w_e11   = 1'b0;
    for (int n = 0; n < NS; n++) begin
      w_reg0 = {STW'(n), 1'b0};
      w_reg1 = {STW'(n), 1'b1};
      w_e00  = parity(32'(w_reg0 & G0));
      w_e01  = parity(32'(w_reg0 & G1));
      w_e10  = parity(32'(w_reg1 & G0));
      w_e11  = parity(32'(w_reg1 & G1));
      o_bm_p0[n] = {1'b0, w_dist0[w_e00]} + {1'b0, w_dist1[w_e01]};
      o_bm_p1[n] = {1'b0, w_dist0[w_e10]} + {1'b0, w_dist1[w_e11]};
    end
  end

endmodule

// File: rtl/viterbi_pmu.sv
// viterbi_pmu -- Viterbi path-metric unit: branch metrics, add-compare-select,
// min-find and normalisation in a single cycle, with a one-deep output
// register toward the survivor memory.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_start                : reinitialise path metrics and step counter
//   i_in_valid/o_in_ready  : soft symbol pair handshake
//   i_in_sym0, i_in_sym1   : soft symbols for code bits 0 and 1
//   o_out_valid/i_out_ready: decision word handshake
//   o_out_dec              : per-state survivor decision (1 = p1 chosen)
//   o_out_best             : lowest-index state with the minimum metric
//   o_out_norm             : minimum subtracted during normalisation
//   o_out_step             : trellis step index of the held word
module viterbi_pmu
  import viterbi_pkg::*;
#(
  parameter int           K   = 4,
  parameter logic [K-1:0] G0  = 4'b1011,
  parameter logic [K-1:0] G1  = 4'b1111,
  parameter int           SW  = 3,
  parameter int           MW  = 8,
  localparam int          NS  = ns_of(K),
  localparam int          STW = stw_of(K)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [SW-1:0]  i_in_sym0,
  input  logic [SW-1:0]  i_in_sym1,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [NS-1:0]  o_out_dec,
  output logic [STW-1:0] o_out_best,
  output logic [MW-1:0]  o_out_norm,
  output logic [15:0]    o_out_step
);

  localparam logic [MW-1:0] PM_MAX = '1;
  localparam logic [NS-1:0][MW-1:0] PM_INIT = {{(NS-1){PM_MAX}}, {MW{1'b0}}};

  logic [NS-1:0][MW-1:0] r_pm;
  logic [15:0]           r_step;
  logic                  r_out_valid;
  logic [NS-1:0]         r_out_dec;
  logic [STW-1:0]        r_out_best;
  logic [MW-1:0]         r_out_norm;
  logic [15:0]           r_out_step;

  logic                  w_xfer;
  logic [NS-1:0][MW-1:0] w_pm_src;
  logic [15:0]           w_step_src;
  logic [NS-1:0][SW:0]   w_bm_p0;
  logic [NS-1:0][SW:0]   w_bm_p1;
  logic [NS-1:0][MW-1:0] w_new;
  logic [NS-1:0][MW-1:0] w_pm_next;
  logic [NS-1:0]         w_dec;
  logic [MW-1:0]         w_cand0;
  logic [MW-1:0]         w_cand1;
  logic [MW-1:0]         w_min;
  logic [STW-1:0]        w_best;

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_xfer     = i_in_valid && o_in_ready;

  // A start coinciding with a transfer feeds the freshly initialised metrics
  // straight into ACS so the first step of the new frame is not lost.
  assign w_pm_src   = i_start ? PM_INIT : r_pm;
  assign w_step_src = i_start ? 16'd0 : r_step;

  viterbi_bmu #(
    .K  (K),
    .G0 (G0),
    .G1 (G1),
    .SW (SW)
  ) u_bmu (
    .i_sym0  (i_in_sym0),
    .i_sym1  (i_in_sym1),
    .o_bm_p0 (w_bm_p0),
    .o_bm_p1 (w_bm_p1)
  );

  // ACS: p0 = {n[K-3:0],0} is (2n mod NS), p1 is the next index up.
  always_comb begin
    w_new   = '0;
    w_dec   = '0;
    w_cand0 = '0;
    w_cand1 = '0;
    for (int n = 0; n < NS; n++) begin
      w_cand0 = MW'(sat_add(32'(w_pm_src[(2 * n) % NS]), 32'(w_bm_p0[n]),
                            32'(PM_MAX)));
      w_cand1 = MW'(sat_add(32'(w_pm_src[(2 * n) % NS + 1]), 32'(w_bm_p1[n]),
                            32'(PM_MAX)));
      // Strict compare: equal candidates keep p0.
      w_dec[n] = (w_cand1 < w_cand0);
      w_new[n] = w_dec[n] ? w_cand1 : w_cand0;
    end
  end

  // Balanced min tree. Each node keeps its left (lower-index) child on a tie,
  // so the root carries the lowest-index minimum.
  logic [MW-1:0]  w_tv [K][NS];
  logic [STW-1:0] w_ti [K][NS];

  always_comb begin
    for (int l = 0; l < K; l++) begin
      for (int i = 0; i < NS; i++) begin
        w_tv[l][i] = '0;
        w_ti[l][i] = '0;
      end
    end
    for (int n = 0; n < NS; n++) begin
      w_tv[0][n] = w_new[n];
      w_ti[0][n] = STW'(n);
    end
    for (int l = 1; l < K; l++) begin
      for (int i = 0; i < (NS >> l); i++) begin
        if (w_tv[l-1][2*i+1] < w_tv[l-1][2*i]) begin
          w_tv[l][i] = w_tv[l-1][2*i+1];
          w_ti[l][i] = w_ti[l-1][2*i+1];
        end else begin
          w_tv[l][i] = w_tv[l-1][2*i];
          w_ti[l][i] = w_ti[l-1][2*i];
        end
      end
    end
    w_min  = w_tv[K-1][0];
    w_best = w_ti[K-1][0];
  end

  // Unreachable states sit at the ceiling and must not drift below it.
  always_comb begin
    w_pm_next = '0;
    for (int n = 0; n < NS; n++) begin
      w_pm_next[n] = (w_new[n] == PM_MAX) ? PM_MAX : w_new[n] - w_min;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pm   <= PM_INIT;
      r_step <= '0;
    end else if (w_xfer) begin
      r_pm   <= w_pm_next;
      r_step <= w_step_src + 16'd1;
    end else if (i_start) begin
      r_pm   <= PM_INIT;
      r_step <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_dec   <= '0;
      r_out_best  <= '0;
      r_out_norm  <= '0;
      r_out_step  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_dec   <= w_dec;
      r_out_best  <= w_best;
      r_out_norm  <= w_min;
      r_out_step  <= w_step_src;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_dec   = r_out_dec;
  assign o_out_best  = r_out_best;
  assign o_out_norm  = r_out_norm;
  assign o_out_step  = r_out_step;

endmodule

// File: tb/tb_viterbi_pmu.sv
// tb_viterbi_pmu -- directed bench for viterbi_pmu with default parameters.
module tb_viterbi_pmu;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sym0;
  logic [2:0]  sym1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_dec;
  logic [2:0]  out_best;
  logic [7:0]  out_norm;
  logic [15:0] out_step;

  int n_tests = 0;
  int n_fail  = 0;

  viterbi_pmu dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_sym0   (sym0),
    .i_in_sym1   (sym1),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_dec   (out_dec),
    .o_out_best  (out_best),
    .o_out_norm  (out_norm),
    .o_out_step  (out_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic st, input logic rdy,
                       input logic [2:0] s0, input logic [2:0] s1);
    in_valid  = v;
    start     = st;
    out_ready = rdy;
    sym0      = s0;
    sym1      = s1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  logic [7:0] pat;
  logic [2:0] enc;
  logic [3:0] ereg;
  logic       ubit;
  logic       c0;
  logic       c1;
  logic       any_sat;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sym0 = '0; sym1 = '0;
    pat = 8'b1011_0010;
    enc = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_dec", out_dec, 0);
    check("rst_best", out_best, 0);
    check("rst_norm", out_norm, 0);
    check("rst_step", out_step, 0);
    check("rst_in_ready", in_ready, 1);

    // start, then (0,0)
    drive(0, 1, 0, 0, 0);
    check("start_alone_valid", out_valid, 0);
    drive(1, 0, 1, 0, 0);
    check("p00_valid", out_valid, 1);
    check("p00_dec", out_dec, 8'h00);
    check("p00_best", out_best, 0);
    check("p00_norm", out_norm, 0);
    check("p00_step", out_step, 0);

    // start while a word is held and stalled must keep it
    drive(0, 1, 0, 0, 0);
    check("start_keeps_valid", out_valid, 1);
    check("start_keeps_step", out_step, 0);

    // (7,7) from freshly started metrics
    drive(1, 0, 1, 7, 7);
    check("p77_dec", out_dec, 8'h00);
    check("p77_best", out_best, 4);
    check("p77_norm", out_norm, 0);
    check("p77_step", out_step, 0);

    drive(0, 0, 1, 0, 0);
    check("drain_valid", out_valid, 0);

    // backpressure: three pairs offered with out_ready low
    drive(1, 0, 0, 0, 0);
    check("bp1_valid", out_valid, 1);
    check("bp1_step", out_step, 1);
    check("bp1_best", out_best, 2);
    check("bp1_norm", out_norm, 7);
    check("bp1_in_ready", in_ready, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 7, 0);
      check("bp_hold_step", out_step, 1);
      check("bp_hold_best", out_best, 2);
      check("bp_hold_norm", out_norm, 7);
      check("bp_hold_in_ready", in_ready, 0);
    end
    drive(1, 0, 1, 7, 0);
    check("bp2_step", out_step, 2);
    check("bp2_best", out_best, 3);
    check("bp2_norm", out_norm, 0);
    drive(1, 0, 1, 1, 1);
    check("bp3_step", out_step, 3);
    check("bp3_valid", out_valid, 1);

    // noiseless encoded stream
    drive(0, 1, 1, 0, 0);
    check("stream_pre_valid", out_valid, 0);
    for (int i = 0; i < 300; i++) begin
      ubit = pat[7 - (i % 8)];
      ereg = {ubit, enc};
      c0   = ^(ereg & 4'b1011);
      c1   = ^(ereg & 4'b1111);
      enc  = ereg[3:1];
      drive(1, 0, 1, c0 ? 3'd7 : 3'd0, c1 ? 3'd7 : 3'd0);
      check("stream_step", out_step, i);
      check("stream_best", out_best, enc);
      check("stream_norm", out_norm, 0);
      if (i >= 3) begin
        any_sat = 1'b0;
        for (int n = 0; n < 8; n++) begin
          if (dut.r_pm[n] == 8'hFF) any_sat = 1'b1;
        end
        check("stream_no_sat", any_sat, 0);
      end
    end

    // run on to step 999, then start together with a transfer
    for (int i = 300; i < 1000; i++) begin
      drive(1, 0, 1, 0, 0);
    end
    check("step_999", out_step, 999);
    drive(1, 1, 1, 7, 7);
    check("st_xfer_step", out_step, 0);
    check("st_xfer_best", out_best, 4);
    check("st_xfer_norm", out_norm, 0);
    check("st_xfer_dec", out_dec, 8'h00);

    // reset in the middle of a stall
    drive(0, 0, 0, 0, 0);
    check("stall_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_step", out_step, 0);
    check("async_rst_dec", out_dec, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    drive(1, 0, 1, 0, 0);
    check("post_rst_step", out_step, 0);
    check("post_rst_best", out_best, 0);
    check("post_rst_norm", out_norm, 0);
    check("post_rst_valid", out_valid, 1);

    // ties: sym0 = sym1 = 3 makes complementary branch labels score 6 vs 8
    // or 7 vs 7
    drive(0, 1, 1, 0, 0);
    drive(1, 0, 1, 3, 3);
    check("tie1_dec", out_dec, 8'h00);
    check("tie1_best", out_best, 0);
    check("tie1_norm", out_norm, 6);
    drive(1, 0, 1, 3, 3);
    check("tie2_dec", out_dec, 8'h00);
    check("tie2_norm", out_norm, 6);
    check("tie2_step", out_step, 1);
    drive(1, 0, 1, 3, 3);
    check("tie3_dec", out_dec, 8'h00);
    check("tie3_best", out_best, 0);
    check("tie3_norm", out_norm, 6);
    drive(1, 0, 1, 3, 3);
    check("tie4_dec", out_dec, 8'h02);
    check("tie4_best", out_best, 0);
    check("tie4_norm", out_norm, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
